// File: rtl/mm_pkg.sv
// Shared constants and sizing helpers for the matrix-multiply to UART sequencer.
package mm_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;

  function automatic int bytes_per_elem(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int num_bytes(input int n, input int w);
    return n * n * bytes_per_elem(w);
  endfunction

  // Counters never collapse to zero width, even for tiny counts.
  function automatic int idx_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/mm_byte_serializer.sv
// Holds the latched result matrix and streams it out byte by byte over a
// valid/ready handshake, element 0 first, little-endian within an element.
module mm_byte_serializer
  import mm_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [N*N*W-1:0]   data_i,
  input  logic               tx_ready_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  output logic               last_accepted_o
);

  localparam int BPE = bytes_per_elem(W);
  localparam int NB  = num_bytes(N, W);
  localparam int IW  = idx_width(NB);
  localparam int EB  = BPE * 8;

  logic [N*N*W-1:0] res_q, res_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [NB*8-1:0]  padded;
  logic             hs;

  assign hs              = valid_q && tx_ready_i;
  assign last_accepted_o = hs && (idx_q == IW'(NB - 1));
  assign tx_valid_o      = valid_q;
  assign tx_data_o       = padded[{idx_q, 3'b000} +: 8];

  // Each element is zero-extended to a whole number of bytes.
  always_comb begin
    padded = '0;
    for (int k = 0; k < N * N; k++) begin
      padded[k*EB +: EB] = EB'(res_q[k*W +: W]);
    end
  end

  always_comb begin
    res_d   = res_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
      idx_d   = '0;
    end else if (load_i) begin
      res_d   = data_i;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (hs) begin
      if (idx_q == IW'(NB - 1)) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      res_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/mm_uart_seq.sv
// Sequencer: clears and runs matrix_mult once per start, latches the result,
// and streams it to the UART transmitter; abort or timeout return to idle.
module mm_uart_seq
  import mm_pkg::*;
#(
  parameter int N       = 3,
  parameter int W       = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             mm_reset_o,
  output logic             mm_enable_o,
  input  logic [N*N*W-1:0] mm_c_i,
  input  logic             mm_done_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int TW = idx_width(TIMEOUT);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          last_accepted;

  assign mm_reset_o  = (state_q == S_CLEAR);
  assign mm_enable_o = (state_q == S_RUN);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

  mm_byte_serializer #(.N(N), .W(W)) u_ser (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .load_i          (state_q == S_LATCH),
    .clear_i         (abort_i),
    .data_i          (mm_c_i),
    .tx_ready_i      (tx_ready_i),
    .tx_data_o       (tx_data_o),
    .tx_valid_o      (tx_valid_o),
    .last_accepted_o (last_accepted)
  );

  // Abort outranks every transition, including a same-cycle start or final handshake.
  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    done_d  = 1'b0;
    err_d   = err_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_CLEAR;
            err_d   = 1'b0;
          end
        end
        S_CLEAR: state_d = S_RUN;
        S_RUN: begin
          if (mm_done_i) begin
            state_d = S_LATCH;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_LATCH: state_d = S_SEND;
        S_SEND: begin
          if (last_accepted) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/mm_uart_seq.md
Name: mm_uart_seq

Overview:
- Sequencer that runs one N x N matrix multiply on the existing matrix_mult core and streams the result bytes to the UART transmitter.
- Sits between the board top level (switches/LEDs, operand registers) and both matrix_mult and transmitter.
- Replaces the hand-written 3x3/8-bit FSM in the top level.
- Adds: dimension/width generalisation, a proper valid/ready byte handshake, a done timeout, and an abort path.

Parameters:
- N, 3, matrix dimension (N x N operands and result).
- W, 8, element width in bits for A, B and C.
- TIMEOUT, 1024, max cycles in RUN waiting for mm_done before flagging error; must be >= 2.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request one multiply+transmit; sampled only in IDLE.
- abort  in  1  forces return to IDLE from any state.
- mm_reset  out  1  reset to matrix_mult.
- mm_enable  out  1  enable to matrix_mult.
- mm_C  in  N*N*W  result from matrix_mult; element k = bits [k*W +: W], k = row*N + col.
- mm_done  in  1  matrix_mult completion flag (level).
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  byte valid.
- tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last byte is accepted.
- err  out  1  sticky timeout flag; cleared by reset or the next accepted start.

Behaviour:
- Reset values: state = IDLE; mm_reset = 0, mm_enable = 0, tx_valid = 0, tx_data = 0, busy = 0, done = 0, err = 0; byte counter and timeout counter = 0.
- Bytes per element: BPE = ceil(W/8). Total bytes: NB = N*N*BPE.
- FSM states and transitions:
  - IDLE: when start = 1, go to CLEAR and clear err.
  - CLEAR: mm_reset = 1 for exactly one cycle, then go to RUN.
  - RUN: mm_enable = 1 and the timeout counter increments every cycle.
    - mm_done = 1: go to LATCH.
    - Counter reaches TIMEOUT-1 without mm_done: set err and go to IDLE.
  - LATCH: capture mm_C into an internal result register (one cycle), deassert mm_enable, byte index = 0, go to SEND.
  - SEND: tx_valid = 1 and tx_data = byte[index].
    - Byte order: element 0 first, little-endian within an element. Byte j of element k = C_k[8j +: 8], zero-padded above W.
    - On a handshake, index increments.
    - Handshake with index = NB-1: pulse done, go to IDLE.
    - tx_data and tx_valid must stay stable while tx_valid && !tx_ready.
- mm_enable is low in every state except RUN. mm_reset is high only in CLEAR.
- done and err are registered outputs.
- abort has priority over all transitions:
  - Next cycle is IDLE; tx_valid drops and counters clear.
  - No done pulse; err unchanged.
  - A byte mid-handshake on the abort cycle counts as not sent.
- A start asserted outside IDLE is ignored (not queued).
- reset mid-operation behaves like abort and also clears err.
- Same-cycle events:
  - mm_done and timeout terminal count together: mm_done wins.
  - start and abort together in IDLE: stay in IDLE.
- The result register holds C for the whole of SEND; changes on mm_C after LATCH have no effect.
- Widths: indexes sized with $clog2(NB) and $clog2(TIMEOUT).
- Minimum latency, start to first tx_valid: 4 cycles plus the matrix_mult run time.

Decomposition:
- Shared package mm_pkg holds:
  - state enum (IDLE, CLEAR, RUN, LATCH, SEND);
  - function bytes_per_elem(W);
  - localparam helpers for NB and counter widths.
- One natural sub-module: mm_byte_serializer. It takes the latched N*N*W vector and a load strobe, and runs the byte index and valid/ready handshake, producing last_accepted. The FSM stays in mm_uart_seq.

Test Plan:
- Stub matrix_mult raises mm_done 5 cycles after enable, mm_C = elements 1..9 (N=3, W=8), tx_ready tied 1 -> mm_reset pulses once; bytes 0x01,0x02,…,0x09 on consecutive cycles; done pulses on the cycle 0x09 is accepted; busy low the next cycle.
- Same stimulus, tx_ready toggled 1-in-3 cycles -> identical byte sequence; tx_data/tx_valid stable during stalls; exactly 9 handshakes.
- W=12, N=2, elements 0xABC,0x123,0x456,0x789 -> bytes BC,0A,23,01,56,04,89,07; done after the 8th handshake.
- mm_done never asserted, TIMEOUT=16 -> err = 1 exactly 16 cycles after RUN entry; state IDLE; no tx_valid.
  - A following start clears err and completes a normal run.
- abort asserted during SEND after byte 4 is accepted -> tx_valid low the next cycle; no done pulse.
  - A new start resends from byte 0x01.
- start pulsed during RUN and SEND -> ignored; only one done pulse; one mm_reset pulse total.
